ahb_bus_arbiter: RTL and testbench

AHB bus arbiter that shares the single AHB master port between up to 16 requesters, for example the DMAC channel master, the CPU and test masters. It takes one `HBUSREQ`/`HLOCK` pair per master and drives a one-hot `HGRANT`. It also drives `HMASTER`/`HMASTLOCK` to the address/data mux and the slaves. It re-arbitrates only at legal AHB points: fixed-length burst boundaries, an unlocked owner, and `HREADY` high.

---
 rtl/ahb_bus_arbiter_pkg.sv | 32 +++
 rtl/ahb_arb_pick.sv | 41 ++++
 rtl/ahb_bus_arbiter.sv | 98 +++++++++
 tb/tb_ahb_bus_arbiter.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/ahb_bus_arbiter_pkg.sv
// Shared AHB encodings and burst-length lookup for the bus arbiter.
// Round-robin arbitration is selected by the macro AHB_ARB_ROUND_ROBIN_EN.
package ahb_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'b000,
        BURST_INCR   = 3'b001,
        BURST_WRAP4  = 3'b010,
        BURST_INCR4  = 3'b011,
        BURST_WRAP8  = 3'b100,
        BURST_INCR8  = 3'b101,
        BURST_WRAP16 = 3'b110,
        BURST_INCR16 = 3'b111
    } hburst_t;

    localparam int MAX_MASTERS = 16;

    // SEQ beats left after the NONSEQ beat, one nibble per HBURST code.
    localparam logic [31:0] BURST_REMAIN = {4'd15, 4'd15, 4'd7, 4'd7, 4'd3, 4'd3, 4'd0, 4'd0};

    function automatic logic [3:0] burst_remaining(input logic [2:0] hburst);
        return BURST_REMAIN[{hburst, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/ahb_arb_pick.sv
// Combinational winner search: lowest index wins, or rotating priority
// starting after ptr when AHB_ARB_ROUND_ROBIN_EN is defined.
module ahb_arb_pick #(
    parameter int NUM_MASTERS = 4
) (
    input  logic [NUM_MASTERS-1:0] req,
`ifdef AHB_ARB_ROUND_ROBIN_EN
    input  logic [3:0]             ptr,
`endif
    output logic                   any,
    output logic [3:0]             winner
);

    always_comb begin
`ifdef AHB_ARB_ROUND_ROBIN_EN
        int k;
        k      = 0;
        any    = 1'b0;
        winner = 4'd0;
        // ptr is always a legal index, so a single wrap subtraction suffices.
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            k = int'(ptr) + i;
            if (k >= NUM_MASTERS) k = k - NUM_MASTERS;
            if (!any && req[k]) begin
                any    = 1'b1;
                winner = 4'(k);
            end
        end
`else
        any    = 1'b0;
        winner = 4'd0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (req[i]) begin
                any    = 1'b1;
                winner = 4'(i);
            end
        end
`endif
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter: burst/lock-aware grant with registered owner tracking.
// Define AHB_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module ahb_bus_arbiter
    import ahb_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic                   HREADY,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [3:0]             HMASTER,
    output logic                   HMASTLOCK
);

    localparam logic [3:0]             DEF_IDX   = 4'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    logic [MAX_MASTERS-1:0] req_pad;
    logic [MAX_MASTERS-1:0] lock_pad;
    logic [3:0]             r_cnt;
    logic [3:0]             r_next;
    logic [3:0]             grant_idx;
    logic [3:0]             pick_idx;
    logic [3:0]             win_idx;
    logic                   pick_any;
    logic                   lock_hold;
    logic                   arb_ok;

    assign req_pad  = MAX_MASTERS'(HBUSREQ);
    assign lock_pad = MAX_MASTERS'(HLOCK);

    always_comb begin
        r_next = r_cnt;
        case (htrans_t'(HTRANS))
            TRANS_NONSEQ: r_next = burst_remaining(HBURST);
            TRANS_SEQ:    r_next = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
            TRANS_IDLE:   r_next = 4'd0;
            default:      r_next = r_cnt;
        endcase
    end

    // Grant may move on the penultimate beat so the next owner has no dead cycle.
    assign lock_hold = lock_pad[HMASTER] & req_pad[HMASTER] & (HTRANS != TRANS_IDLE);
    assign arb_ok    = HREADY & (r_next <= 4'd1) & ~lock_hold;

`ifdef AHB_ARB_ROUND_ROBIN_EN
    logic [3:0] rr_ptr;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rr_ptr <= DEF_IDX;
        end else if (arb_ok && pick_any && (win_idx != grant_idx)) begin
            rr_ptr <= win_idx;
        end
    end
`endif

    ahb_arb_pick #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_pick (
        .req    (HBUSREQ),
`ifdef AHB_ARB_ROUND_ROBIN_EN
        .ptr    (rr_ptr),
`endif
        .any    (pick_any),
        .winner (pick_idx)
    );

    assign win_idx = pick_any ? pick_idx : DEF_IDX;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_cnt     <= 4'd0;
            grant_idx <= DEF_IDX;
            HGRANT    <= DEF_GRANT;
            HMASTER   <= DEF_IDX;
            HMASTLOCK <= 1'b0;
        end else begin
            // Ownership follows the grant by one accepted address phase.
            if (HREADY) begin
                r_cnt     <= r_next;
                HMASTER   <= grant_idx;
                HMASTLOCK <= lock_pad[grant_idx];
            end
            if (arb_ok) begin
                grant_idx <= win_idx;
                HGRANT    <= NUM_MASTERS'(1) << win_idx;
            end
        end
    end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter with hand-computed per-cycle expectations.
// Round-robin vectors run when AHB_ARB_ROUND_ROBIN_EN is defined.
module tb_ahb_bus_arbiter;
    import ahb_bus_arbiter_pkg::*;

    localparam logic [1:0] TI = 2'b00;
    localparam logic [1:0] TN = 2'b10;
    localparam logic [1:0] TS = 2'b11;
    localparam logic [2:0] BS = 3'b000;
    localparam logic [2:0] B4 = 3'b011;
    localparam logic [2:0] B8 = 3'b101;
    localparam logic [2:0] B16 = 3'b111;

    typedef struct packed {
        logic [3:0] grant;
        logic [3:0] master;
        logic       lock;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] busreq = 4'd0;
    logic [3:0] hlock = 4'd0;
    logic       ready = 1'b1;
    logic [1:0] trans = TI;
    logic [2:0] burst = BS;
    logic [3:0] grant;
    logic [3:0] master;
    logic       mlock;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  mon_e;
    string mon_n;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    ahb_bus_arbiter #(
        .NUM_MASTERS(4),
        .DEFAULT_MASTER(0)
    ) dut (
        .HCLK      (clk),
        .HRESET    (rst),
        .HBUSREQ   (busreq),
        .HLOCK     (hlock),
        .HREADY    (ready),
        .HTRANS    (trans),
        .HBURST    (burst),
        .HGRANT    (grant),
        .HMASTER   (master),
        .HMASTLOCK (mlock)
    );

    task automatic check(input string n, input string f, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %b expected %b", n, f, act, exp);
        end
    endtask

    // Monitor: after every clock edge compare outputs with the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            check(mon_n, "HGRANT", grant, mon_e.grant);
            check(mon_n, "HMASTER", master, mon_e.master);
            check(mon_n, "HMASTLOCK", {3'b000, mlock}, {3'b000, mon_e.lock});
        end
    end

    task automatic vec(input logic r, input logic [3:0] req, input logic [3:0] lk, input logic rdy,
                       input logic [1:0] tr, input logic [2:0] bu,
                       input logic [3:0] eg, input logic [3:0] em, input logic el, input string nm);
        @(negedge clk);
        rst    = r;
        busreq = req;
        hlock  = lk;
        ready  = rdy;
        trans  = tr;
        burst  = bu;
        exp_q.push_back(exp_t'{grant: eg, master: em, lock: el});
        name_q.push_back(nm);
    endtask

    initial begin
        vec(1, 4'b0000, 4'b0000, 1, TI, BS, 4'b0001, 4'd0, 1'b0, "reset0");
        vec(1, 4'b0000, 4'b0000, 1, TI, BS, 4'b0001, 4'd0, 1'b0, "reset1");
        vec(0, 4'b0000, 4'b0000, 1, TI, BS, 4'b0001, 4'd0, 1'b0, "idle_default");
`ifdef AHB_ARB_ROUND_ROBIN_EN
        vec(0, 4'b1111, 4'b0000, 1, TN, BS, 4'b0010, 4'd0, 1'b0, "rr_all1");
        vec(0, 4'b1111, 4'b0000, 1, TN, BS, 4'b0100, 4'd1, 1'b0, "rr_all2");
        vec(0, 4'b1111, 4'b0000, 1, TN, BS, 4'b1000, 4'd2, 1'b0, "rr_all3");
        vec(0, 4'b1111, 4'b0000, 1, TN, BS, 4'b0001, 4'd3, 1'b0, "rr_all4");
        vec(0, 4'b1111, 4'b0000, 1, TN, BS, 4'b0010, 4'd0, 1'b0, "rr_all5");
        vec(0, 4'b1111, 4'b0000, 1, TN, BS, 4'b0100, 4'd1, 1'b0, "rr_all6");
        vec(0, 4'b1011, 4'b0000, 1, TN, BS, 4'b1000, 4'd2, 1'b0, "rr_skip1");
        vec(0, 4'b1011, 4'b0000, 1, TN, BS, 4'b0001, 4'd3, 1'b0, "rr_skip2");
        vec(0, 4'b1011, 4'b0000, 1, TN, BS, 4'b0010, 4'd0, 1'b0, "rr_skip3");
        vec(0, 4'b1011, 4'b0000, 1, TN, BS, 4'b1000, 4'd1, 1'b0, "rr_skip4");
        vec(0, 4'b1011, 4'b0000, 1, TN, BS, 4'b0001, 4'd3, 1'b0, "rr_skip5");
`else
        vec(0, 4'b0000, 4'b0000, 1, TI, BS, 4'b0001, 4'd0, 1'b0, "idle_default_b");
        vec(0, 4'b0110, 4'b0000, 1, TI, BS, 4'b0010, 4'd0, 1'b0, "prio_low_wins");
        vec(0, 4'b0110, 4'b0000, 1, TN, BS, 4'b0010, 4'd1, 1'b0, "prio_hold");
        vec(0, 4'b0100, 4'b0000, 1, TN, BS, 4'b0100, 4'd1, 1'b0, "prio_drop");
        vec(0, 4'b0100, 4'b0000, 1, TN, BS, 4'b0100, 4'd2, 1'b0, "master_lag");
        vec(0, 4'b0110, 4'b0000, 1, TN, B8, 4'b0100, 4'd2, 1'b0, "incr8_b1");
        for (int i = 0; i < 5; i++)
            vec(0, 4'b0110, 4'b0000, 1, TS, B8, 4'b0100, 4'd2, 1'b0, "incr8_hold");
        vec(0, 4'b0110, 4'b0000, 1, TS, B8, 4'b0010, 4'd2, 1'b0, "incr8_b7_handover");
        vec(0, 4'b0110, 4'b0000, 1, TS, B8, 4'b0010, 4'd1, 1'b0, "incr8_b8_master");
        vec(0, 4'b0100, 4'b0000, 1, TN, B4, 4'b0010, 4'd1, 1'b0, "incr4_b1");
        vec(0, 4'b0100, 4'b0000, 1, TS, B4, 4'b0010, 4'd1, 1'b0, "incr4_b2");
        for (int i = 0; i < 3; i++)
            vec(0, 4'b0100, 4'b0000, 0, TS, B4, 4'b0010, 4'd1, 1'b0, "wait_frozen");
        vec(0, 4'b0100, 4'b0000, 1, TS, B4, 4'b0100, 4'd1, 1'b0, "incr4_b3_handover");
        vec(0, 4'b0100, 4'b0000, 1, TS, B4, 4'b0100, 4'd2, 1'b0, "incr4_b4_master");
        vec(0, 4'b1000, 4'b1000, 1, TI, BS, 4'b1000, 4'd2, 1'b0, "lock_grant");
        vec(0, 4'b1000, 4'b1000, 1, TI, BS, 4'b1000, 4'd3, 1'b1, "lock_owner");
        vec(0, 4'b1001, 4'b1000, 1, TN, BS, 4'b1000, 4'd3, 1'b1, "lock_hold1");
        vec(0, 4'b1001, 4'b1000, 1, TN, BS, 4'b1000, 4'd3, 1'b1, "lock_hold2");
        vec(0, 4'b1001, 4'b0000, 1, TI, BS, 4'b0001, 4'd3, 1'b0, "lock_release");
        vec(0, 4'b0001, 4'b0000, 1, TI, BS, 4'b0001, 4'd0, 1'b0, "lock_after");
        vec(0, 4'b0000, 4'b0000, 1, TI, BS, 4'b0001, 4'd0, 1'b0, "idle_default2");
        vec(0, 4'b0010, 4'b0000, 1, TI, BS, 4'b0010, 4'd0, 1'b0, "pre_reset_grant");
        vec(0, 4'b0010, 4'b0000, 1, TN, B16, 4'b0010, 4'd1, 1'b0, "incr16_b1");
        vec(1, 4'b0010, 4'b0000, 1, TS, B16, 4'b0001, 4'd0, 1'b0, "reset_midburst");
        vec(0, 4'b0010, 4'b0000, 1, TS, B16, 4'b0010, 4'd0, 1'b0, "reset_clears_r");
`endif
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
